// File: rtl/regf_arbiter.sv
// regf_arbiter: two-requester round-robin arbiter and access sequencer
// for the shared register file. Requester 0 is the I2C slave controller,
// requester 1 the local/debug port. One access at a time is issued to the
// register file. Read data is captured after ACCESS_LAT cycles and handed
// back with a one-cycle done pulse. Every output is a register.
module regf_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ACCESS_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    input  logic                  req0_rw,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_done,
    output logic [DATA_WIDTH-1:0] req0_rdata,

    input  logic                  req1_valid,
    input  logic                  req1_rw,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req1_rdata,

    output logic                  out_regf_req,
    output logic                  out_regf_rw,
    output logic [ADDR_WIDTH-1:0] out_regf_addr,
    output logic [DATA_WIDTH-1:0] out_regf_write_data,
    input  logic [DATA_WIDTH-1:0] regf_read_data,

    output logic                  busy,
    output logic                  last_grant
);

    // ACCESS_LAT outside 1..15 is illegal; clamping keeps the wait counter
    // from wrapping if a bad value slips through.
    localparam logic [3:0] LAT_LOAD = (ACCESS_LAT < 1)  ? 4'd1  :
                                      (ACCESS_LAT > 15) ? 4'd15 :
                                      4'(ACCESS_LAT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic       ptr_q,   ptr_d;      // requester favoured on a tie
    logic       grant_q, grant_d;    // requester owning the current access
    logic [3:0] cnt_q,   cnt_d;      // remaining WAIT cycles

    logic any_req;
    logic pick;

    logic                  req0_ready_d, req1_ready_d;
    logic                  req0_done_d,  req1_done_d;
    logic [DATA_WIDTH-1:0] req0_rdata_d, req1_rdata_d;
    logic                  regf_req_d,   regf_rw_d;
    logic [ADDR_WIDTH-1:0] regf_addr_d;
    logic [DATA_WIDTH-1:0] regf_wdata_d;
    logic                  busy_d,       last_grant_d;

    // Round-robin pick: pointer breaks ties, a lone requester always wins
    always_comb begin
        any_req = req0_valid | req1_valid;
        pick    = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> ISSUE -> WAIT (ACCESS_LAT cycles) -> DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (cnt_q <= 4'd1) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic: computes next values of every registered output so that
    // each pulse lands in the cycle of the state it belongs to
    always_comb begin
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        req0_ready_d = 1'b0;
        req1_ready_d = 1'b0;
        req0_done_d  = 1'b0;
        req1_done_d  = 1'b0;
        req0_rdata_d = req0_rdata;
        req1_rdata_d = req1_rdata;
        regf_req_d   = 1'b0;
        regf_rw_d    = out_regf_rw;
        regf_addr_d  = out_regf_addr;
        regf_wdata_d = out_regf_write_data;
        last_grant_d = last_grant;
        busy_d       = (state_d != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    // Fields go straight into the regf output registers and
                    // hold there until the next grant.
                    grant_d      = pick;
                    last_grant_d = pick;
                    regf_req_d   = 1'b1;
                    regf_rw_d    = pick ? req1_rw    : req0_rw;
                    regf_addr_d  = pick ? req1_addr  : req0_addr;
                    regf_wdata_d = pick ? req1_wdata : req0_wdata;
                    req0_ready_d = ~pick;
                    req1_ready_d = pick;
                end
            end
            ST_ISSUE: begin
                cnt_d = LAT_LOAD;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    req0_done_d = ~grant_q;
                    req1_done_d = grant_q;
                    if (out_regf_rw) begin
                        if (grant_q) begin
                            req1_rdata_d = regf_read_data;
                        end else begin
                            req0_rdata_d = regf_read_data;
                        end
                    end
                end
            end
            ST_DONE: begin
                ptr_d = ~grant_q;
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q               <= 1'b0;
            grant_q             <= 1'b0;
            cnt_q               <= '0;
            req0_ready          <= 1'b0;
            req1_ready          <= 1'b0;
            req0_done           <= 1'b0;
            req1_done           <= 1'b0;
            req0_rdata          <= '0;
            req1_rdata          <= '0;
            out_regf_req        <= 1'b0;
            out_regf_rw         <= 1'b0;
            out_regf_addr       <= '0;
            out_regf_write_data <= '0;
            busy                <= 1'b0;
            last_grant          <= 1'b0;
        end else begin
            ptr_q               <= ptr_d;
            grant_q             <= grant_d;
            cnt_q               <= cnt_d;
            req0_ready          <= req0_ready_d;
            req1_ready          <= req1_ready_d;
            req0_done           <= req0_done_d;
            req1_done           <= req1_done_d;
            req0_rdata          <= req0_rdata_d;
            req1_rdata          <= req1_rdata_d;
            out_regf_req        <= regf_req_d;
            out_regf_rw         <= regf_rw_d;
            out_regf_addr       <= regf_addr_d;
            out_regf_write_data <= regf_wdata_d;
            busy                <= busy_d;
            last_grant          <= last_grant_d;
        end
    end

endmodule
